// File: rtl/dds_param_ctrl_pkg.sv
// Shared widths, key indices, FSM encoding and the per-digit step table
// for the DDS front-panel controller.
package dds_param_ctrl_pkg;

  localparam int FREQ_W   = 20;
  localparam int FTW_W    = 32;
  localparam int NUM_KEYS = 4;

  localparam int KEY_WAVE = 0;
  localparam int KEY_DIG  = 1;
  localparam int KEY_INC  = 2;
  localparam int KEY_DEC  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  // Decimal step for the digit being edited; one extra bit of headroom so
  // freq + step never wraps.
  function automatic logic [FREQ_W:0] step_of(input logic [2:0] digit);
    logic [FREQ_W:0] step;
    case (digit)
      3'd0:    step = 21'd1;
      3'd1:    step = 21'd10;
      3'd2:    step = 21'd100;
      3'd3:    step = 21'd1000;
      3'd4:    step = 21'd10000;
      3'd5:    step = 21'd100000;
      default: step = 21'd1;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/dds_param_ctrl_key_filter.sv
// One key: 2-FF synchroniser, debounce counter and a single-cycle press
// pulse on an accepted high->low transition (release gives no pulse).
module dds_param_ctrl_key_filter #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             press_reg;

  // Bring the asynchronous key into clk; idle level of a key is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= 2'b11;
    else        sync_reg <= {sync_reg[0], key_raw};
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg <= 1'b1;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      if (sync_reg[1] != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= sync_reg[1];
          cnt_reg   <= '0;
          press_reg <= ~sync_reg[1];
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/dds_param_ctrl.sv
// Front-panel controller: four debounced keys edit frequency / waveform and
// a small FSM turns the frequency into a tuning word with an update strobe.
module dds_param_ctrl
  import dds_param_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int FREQ_MIN        = 1,
  parameter int FREQ_MAX        = 999_999,
  parameter int FREQ_DEFAULT    = 1000,
  parameter int NUM_WAVES       = 5,
  parameter int FTW_K           = 5_629_500
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        key_in,
  output logic [FREQ_W-1:0] disp_data,
  output logic [2:0]        flag,
  output logic [2:0]        wave_sel,
  output logic [FTW_W-1:0]  ftw,
  output logic              ftw_valid,
  output logic [2:0]        digit_sel
);

  logic [NUM_KEYS-1:0] press;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      dds_param_ctrl_key_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
        .clk    (clk),
        .rst_n  (reset_n),
        .key_raw(key_in[gi]),
        .press  (press[gi])
      );
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [FREQ_W-1:0]   freq_reg, freq_next;
  logic [2:0]          wave_reg, wave_next;
  logic [2:0]          digit_reg, digit_next;
  logic [NUM_KEYS-1:0] pend_reg, pend_next;
  logic [FTW_W-1:0]    ftw_reg, ftw_next;

  logic [NUM_KEYS-1:0] req;
  logic [FREQ_W:0]     step;
  logic [FREQ_W:0]     freq_ext;
  logic [FREQ_W:0]     sum;
  logic [FREQ_W-1:0]   inc_val, dec_val;
  logic                do_wave, do_inc, do_dec;

  // Saturating step arithmetic in 21 bits; operands for the IDLE decision.
  always_comb begin
    req      = pend_reg | press;
    step     = step_of(digit_reg);
    freq_ext = {1'b0, freq_reg};
    sum      = freq_ext + step;
    inc_val  = (sum > 21'(FREQ_MAX)) ? FREQ_W'(FREQ_MAX) : sum[FREQ_W-1:0];
    dec_val  = (freq_ext < 21'(FREQ_MIN) + step) ? FREQ_W'(FREQ_MIN)
                                                 : FREQ_W'(freq_ext - step);
    do_wave  = req[KEY_WAVE];
    do_inc   = req[KEY_INC] & ~req[KEY_DEC];
    do_dec   = req[KEY_DEC] & ~req[KEY_INC];
  end

  // Next-state logic. Requests not serviced in IDLE wait in pend_reg; a
  // digit request loses to wave/inc/dec and is serviced on the next IDLE.
  always_comb begin
    state_next = state_reg;
    freq_next  = freq_reg;
    wave_next  = wave_reg;
    digit_next = digit_reg;
    pend_next  = pend_reg;
    ftw_next   = ftw_reg;
    case (state_reg)
      S_IDLE: begin
        if (do_wave || do_inc || do_dec) begin
          if (do_wave)
            wave_next = (wave_reg == 3'(NUM_WAVES - 1)) ? 3'd0 : wave_reg + 3'd1;
          if (do_inc) freq_next = inc_val;
          if (do_dec) freq_next = dec_val;
          pend_next          = '0;
          pend_next[KEY_DIG] = req[KEY_DIG];
          state_next         = S_MULT;
        end else begin
          if (req[KEY_DIG])
            digit_next = (digit_reg == 3'd5) ? 3'd0 : digit_reg + 3'd1;
          pend_next = '0;
        end
      end
      S_MULT: begin
        // Tuning word = (freq * FTW_K) >> 16; only the upper product bits are kept.
        ftw_next   = FTW_W'((48'(freq_reg) * 48'(FTW_K)) >> 16);
        pend_next  = pend_reg | press;
        state_next = S_LOAD;
      end
      S_LOAD: begin
        pend_next  = pend_reg | press;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State registers; reset restarts the default tuning-word computation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_MULT;
      freq_reg  <= FREQ_W'(FREQ_DEFAULT);
      wave_reg  <= '0;
      digit_reg <= '0;
      pend_reg  <= '0;
      ftw_reg   <= '0;
    end else begin
      state_reg <= state_next;
      freq_reg  <= freq_next;
      wave_reg  <= wave_next;
      digit_reg <= digit_next;
      pend_reg  <= pend_next;
      ftw_reg   <= ftw_next;
    end
  end

  assign disp_data = freq_reg;
  assign flag      = wave_reg;
  assign wave_sel  = wave_reg;
  assign digit_sel = digit_reg;
  assign ftw       = ftw_reg;
  assign ftw_valid = (state_reg == S_LOAD);

endmodule
